// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC owner, imem req/ack handshake, IF/ID feed.
// Optional FETCH_BUF_EN keeps a word that arrives during a stall, so it is not fetched again.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_IFWrite,
    input  logic        IF_flush,
    input  logic [31:0] target_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        IDLE,
        REQ
`ifdef FETCH_BUF_EN
        , HOLD
`endif
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        redir_pend_reg, redir_pend_next;
    logic [31:0] redir_pc_reg, redir_pc_next;
`ifdef FETCH_BUF_EN
    logic [31:0] buf_reg, buf_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            redir_pend_reg <= 1'b0;
            redir_pc_reg   <= 32'h0;
`ifdef FETCH_BUF_EN
            buf_reg        <= 32'h0;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            redir_pend_reg <= redir_pend_next;
            redir_pc_reg   <= redir_pc_next;
`ifdef FETCH_BUF_EN
            buf_reg        <= buf_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        redir_pend_next = redir_pend_reg;
        redir_pc_next   = redir_pc_reg;
`ifdef FETCH_BUF_EN
        buf_next        = buf_reg;
`endif
        imem_req        = 1'b0;
        fetch_valid     = 1'b0;
        instr_out       = 32'h0;

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (IF_flush || redir_pend_reg) begin
                        // Word belongs to the squashed path; the redirect wins.
                        pc_next         = IF_flush ? target_pc : redir_pc_reg;
                        redir_pend_next = 1'b0;
                    end else if (PC_IFWrite) begin
                        fetch_valid = 1'b1;
                        instr_out   = imem_rdata;
                        pc_next     = pc_reg + PC_STEP;
                    end else begin
`ifdef FETCH_BUF_EN
                        buf_next   = imem_rdata;
                        state_next = HOLD;
`endif
                        // Without the buffer the word is dropped and the same pc is reissued.
                    end
                end else if (IF_flush) begin
                    // Address must stay stable until ack, so remember the redirect.
                    redir_pend_next = 1'b1;
                    redir_pc_next   = target_pc;
                end
            end
`ifdef FETCH_BUF_EN
            HOLD: begin
                fetch_valid = 1'b1;
                instr_out   = buf_reg;
                if (IF_flush) begin
                    pc_next    = target_pc;
                    buf_next   = 32'h0;
                    state_next = REQ;
                end else if (PC_IFWrite) begin
                    pc_next    = pc_reg + PC_STEP;
                    state_next = REQ;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_addr = pc_reg;
    assign pc_out    = pc_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns addr ^ 32'hA5A5_0000 whenever ack is driven.
module tb_if_fetch_unit;

    localparam logic [31:0] XORV = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_IFWrite;
    logic        IF_flush;
    logic [31:0] target_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        fetch_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ XORV;

    if_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .PC_IFWrite (PC_IFWrite),
        .IF_flush   (IF_flush),
        .target_pc  (target_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .instr_out  (instr_out),
        .fetch_valid(fetch_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reset, release, and leave the DUT in REQ at pc 0x3000.
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; IF_flush = 1'b0; PC_IFWrite = 1'b1; target_pc = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; IF_flush = 1'b0; PC_IFWrite = 1'b1; target_pc = 32'h0;
        tick();
        tick();
        sample();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc", pc_out, 32'h3000);
        chk("rst_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);

        // Reset release with zero-wait memory
        tick();
        rst = 1'b0;
        sample();
        chk("rel_idle_req", {31'h0, imem_req}, 32'h0);
        tick();
        imem_ack = 1'b1;
        sample();
        chk("rel_req_rise", {31'h0, imem_req}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("zw_pc", pc_out, 32'h3000 + 32'(i * 4));
            chk("zw_valid", {31'h0, fetch_valid}, 32'h1);
            chk("zw_instr", instr_out, (32'h3000 + 32'(i * 4)) ^ XORV);
            tick();
            sample();
        end

        // Two-cycle latency: valid pattern 0,1,0,1 with address held until ack
        do_reset();
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'b0;
            sample();
            chk("lat_valid0", {31'h0, fetch_valid}, 32'h0);
            chk("lat_addr_wait", imem_addr, 32'h3000 + 32'(i * 4));
            tick();
            imem_ack = 1'b1;
            sample();
            chk("lat_valid1", {31'h0, fetch_valid}, 32'h1);
            chk("lat_addr_ack", imem_addr, 32'h3000 + 32'(i * 4));
            tick();
        end

        // Stall on the ack for 0x3004
        do_reset();
        imem_ack = 1'b1;
        tick();
        PC_IFWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
`ifdef FETCH_BUF_EN
            if (i == 0) begin
                chk("stall_req_valid", {31'h0, fetch_valid}, 32'h0);
                chk("stall_req_req", {31'h0, imem_req}, 32'h1);
            end else begin
                chk("hold_req", {31'h0, imem_req}, 32'h0);
                chk("hold_valid", {31'h0, fetch_valid}, 32'h1);
                chk("hold_instr", instr_out, 32'h3004 ^ XORV);
                chk("hold_pc", pc_out, 32'h3004);
            end
`else
            chk("reissue_req", {31'h0, imem_req}, 32'h1);
            chk("reissue_addr", imem_addr, 32'h3004);
            chk("reissue_valid", {31'h0, fetch_valid}, 32'h0);
`endif
            tick();
        end
        PC_IFWrite = 1'b1;
        sample();
        chk("release_valid", {31'h0, fetch_valid}, 32'h1);
        chk("release_instr", instr_out, 32'h3004 ^ XORV);
        tick();
        sample();
        chk("after_stall_addr", imem_addr, 32'h3008);
        chk("after_stall_req", {31'h0, imem_req}, 32'h1);

        // Flush coinciding with the ack for 0x3008
        IF_flush = 1'b1; target_pc = 32'h4000;
        sample();
        chk("flush_ack_valid", {31'h0, fetch_valid}, 32'h0);
        chk("flush_ack_instr", instr_out, 32'h0);
        tick();
        IF_flush = 1'b0;
        sample();
        chk("flush_ack_addr", imem_addr, 32'h4000);
        chk("flush_ack_newinstr", instr_out, 32'h4000 ^ XORV);
        tick();

        // Two flushes during a wait; the later target wins after the ack
        imem_ack = 1'b0; IF_flush = 1'b1; target_pc = 32'h5000;
        sample();
        chk("fw_wait_addr", imem_addr, 32'h4004);
        tick();
        target_pc = 32'h6000;
        tick();
        IF_flush = 1'b0;
        sample();
        chk("fw_addr_stable", imem_addr, 32'h4004);
        tick();
        imem_ack = 1'b1;
        sample();
        chk("fw_ack_dropped", {31'h0, fetch_valid}, 32'h0);
        tick();
        imem_ack = 1'b0;
        sample();
        chk("fw_redir_addr", imem_addr, 32'h6000);
        tick();

        // PC wrap at the top of the address space
        imem_ack = 1'b1; IF_flush = 1'b1; target_pc = 32'hFFFF_FFFC;
        tick();
        IF_flush = 1'b0;
        sample();
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_valid", {31'h0, fetch_valid}, 32'h1);
        tick();
        sample();
        chk("wrap_addr_zero", imem_addr, 32'h0);

        // Reset while waiting; late ack lands in IDLE and is ignored
        imem_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; imem_ack = 1'b1;
        sample();
        chk("late_ack_req", {31'h0, imem_req}, 32'h0);
        chk("late_ack_valid", {31'h0, fetch_valid}, 32'h0);
        chk("late_ack_instr", instr_out, 32'h0);
        chk("late_ack_pc", pc_out, 32'h3000);
        tick();
        sample();
        chk("post_rst_addr", imem_addr, 32'h3000);
        chk("post_rst_req", {31'h0, imem_req}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the pipelined CPU: owns the PC, runs a req/ack handshake to instruction memory, and drives the PC/instruction pair into the IF/ID pipeline register. Honours the hazard unit's `PC_IFWrite` stall and the `IF_flush` branch redirect, presenting a zero instruction (NOP bubble) whenever no valid instruction is available. Sits between instruction memory and `if_id`.

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded on reset
- `PC_STEP`, 4, sequential PC increment

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `PC_IFWrite`  in  1  1 = IF/ID accepts this cycle; 0 = stall, hold PC
- `IF_flush`  in  1  redirect request, wins over `PC_IFWrite`
- `target_pc`  in  32  redirect destination, sampled when `IF_flush`=1
- `imem_req`  out  1  memory request
- `imem_addr`  out  32  fetch address, equals `pc`
- `imem_ack`  in  1  rdata valid this cycle; ignored unless `imem_req`=1
- `imem_rdata`  in  32  instruction word
- `pc_out`  out  32  to `if_id.pc_in`
- `instr_out`  out  32  to `if_id.din`; 0 when `fetch_valid`=0
- `fetch_valid`  out  1  `instr_out` carries a real instruction

## Operation
- Registers: `pc`[31:0], state {IDLE, REQ, HOLD}, `redir_pend`, `redir_pc`[31:0], `buf`[31:0] (HOLD only).
- Reset (`rst`=1 at edge): `pc`←RESET_PC, state←IDLE, `redir_pend`←0, `buf`←0. While in IDLE: `imem_req`=0, `fetch_valid`=0, `instr_out`=0, `pc_out`=`imem_addr`=`pc`.
- IDLE → REQ unconditionally next edge.
- REQ: `imem_req`=1, `imem_addr`=`pc` held stable until ack.
  - ack & (`IF_flush` | `redir_pend`): data discarded, `fetch_valid`=0; `pc`←`target_pc` if `IF_flush` else `redir_pc`; `redir_pend`←0; stay REQ.
  - ack & `PC_IFWrite`: `fetch_valid`=1, `instr_out`=`imem_rdata`, `pc_out`=`pc`; `pc`←`pc`+PC_STEP; stay REQ.
  - ack & !`PC_IFWrite`: see Configuration.
  - no ack: `fetch_valid`=0; if `IF_flush`, `redir_pend`←1, `redir_pc`←`target_pc` (latest flush overwrites earlier one).
- HOLD: `imem_req`=0, `fetch_valid`=1, `instr_out`=`buf`, `pc_out`=`pc`.
  - `IF_flush`: `pc`←`target_pc`, buffer dropped, → REQ.
  - `PC_IFWrite`: `pc`←`pc`+PC_STEP, → REQ.
  - else stay HOLD.
- PC arithmetic: 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- Reset mid-transaction: outstanding request abandoned; a late ack arriving in IDLE is ignored.

## Timing
- `imem_req`, `imem_addr`, `pc_out` are functions of registered state; `instr_out` and `fetch_valid` are combinational from state and `imem_rdata`/`imem_ack`/`IF_flush` in the same cycle. `if_id` samples them at the next edge.
- First `imem_req` is asserted 1 cycle after `rst` deasserts.
- Zero-wait memory (ack in the same cycle as req): 1 instruction per cycle, `pc` advancing every cycle.
- An N-cycle memory delay produces N-1 bubbles.
- Flush with ack present: the new target is requested on the next cycle.
- Flush without ack: the redirect takes effect in the cycle after the ack.

## Configuration
- `FETCH_BUF_EN` defined:
  - REQ & ack & !`PC_IFWrite` & !flush → `buf`←`imem_rdata`, enter HOLD; `fetch_valid`=0 in that cycle.
  - Result: no refetch after a stall.
- Undefined:
  - HOLD state and `buf` are absent.
  - Same condition discards the data and stays in REQ with `pc` unchanged, so the same address is reissued. Costs one memory access per stalled cycle.

## Test plan
- Reset release, zero-wait memory returning `addr`^32'hA5A5_0000:
  - `imem_req` rises 1 cycle after `rst`=0.
  - `pc_out` = 0x3000, 0x3004, 0x3008 on consecutive cycles, each with `fetch_valid`=1.
- 2-cycle memory latency:
  - `fetch_valid` pattern 0,1,0,1.
  - `imem_addr` stable at 0x3000 until ack.
- Stall for 3 cycles on ack at 0x3004:
  - With `FETCH_BUF_EN`: HOLD holds `instr_out` at the 0x3004 word, `imem_req`=0; 0x3008 is requested after release.
  - Without: 0x3004 is reissued every cycle.
- `IF_flush` with `target_pc`=0x4000 in the same cycle as the ack for 0x3008:
  - 0x3008 data dropped (`fetch_valid`=0); next `imem_addr`=0x4000.
- `IF_flush` to 0x5000 during a wait, then `IF_flush` to 0x6000, then ack:
  - Ack data dropped; next `imem_addr`=0x6000.
- `rst` asserted while waiting for ack:
  - A late ack is ignored.
  - `pc_out`=0x3000 and `imem_req`=0 while in IDLE.
